// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU sequencer types and slice width
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam int SLICE_W = 4;
endpackage

// File: rtl/cla_seq_addsub_if.sv
// rtl/cla_seq_addsub_if.sv - request/response bundle of the sequential add/sub unit
interface cla_seq_addsub_if #(parameter int WIDTH = 16);
  logic             start;
  logic             sub;
  logic             sat_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovfl;
  logic             cout;

  modport master (output start, sub, sat_en, a, b,
                  input  busy, done, result, ovfl, cout);
  modport slave  (input  start, sub, sat_en, a, b,
                  output busy, done, result, ovfl, cout);
endinterface

// File: rtl/cla_seq_addsub_cla4.sv
// rtl/cla_seq_addsub_cla4.sv - 4-bit carry-lookahead adder slice
module CLA_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_prop_val,
  output logic       o_gen_val
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum      = w_p ^ w_c[3:0];
  assign o_cout     = w_c[4];
  assign o_prop_val = &w_p;
  assign o_gen_val  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                    | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// File: rtl/cla_seq_addsub.sv
// rtl/cla_seq_addsub.sv - WIDTH-bit add/sub run nibble-serially through one CLA slice
module cla_seq_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  cla_seq_addsub_if.slave     bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_sat_en;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_result;
  logic             r_ovfl;
  logic             r_cout;

  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;
  logic [1:0]         w_unused_pg;
  logic [WIDTH-1:0]   w_sum_full;
  logic               w_ovfl;
  logic               w_last;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;

  assign w_a_nib = r_op_a[r_idx*SLICE_W +: SLICE_W];
  assign w_b_nib = r_op_b[r_idx*SLICE_W +: SLICE_W];
  assign w_last  = (r_idx == LAST_IDX);

  CLA_4bit u_slice (
    .i_a        (w_a_nib),
    .i_b        (w_b_nib),
    .i_cin      (r_carry),
    .o_sum      (w_slice_sum),
    .o_cout     (w_slice_cout),
    .o_prop_val (w_unused_pg[0]),
    .o_gen_val  (w_unused_pg[1])
  );

  // Overflow is judged on the fully assembled sum, including the nibble produced this cycle
  always_comb begin
    w_sum_full = r_sum;
    w_sum_full[r_idx*SLICE_W +: SLICE_W] = w_slice_sum;
    w_ovfl = (r_op_a[MSB] == r_op_b[MSB]) && (w_sum_full[MSB] != r_op_a[MSB]);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sat_en <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_ovfl   <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: the +1 rides in as the first slice carry
      r_op_a   <= bus.a;
      r_op_b   <= bus.sub ? ~bus.b : bus.b;
      r_sat_en <= bus.sat_en;
      r_carry  <= bus.sub;
      r_idx    <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_full;
      r_carry <= w_slice_cout;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_ovfl <= w_ovfl;
        r_cout <= w_slice_cout;
        if (r_sat_en && w_ovfl) r_result <= r_op_a[MSB] ? SAT_MIN : SAT_MAX;
        else                    r_result <= w_sum_full;
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.ovfl   = r_ovfl;
  assign bus.cout   = r_cout;
endmodule

// File: tb/tb_cla_seq_addsub.sv
// tb/tb_cla_seq_addsub.sv - self-checking bench for cla_seq_addsub
module tb_cla_seq_addsub;
  localparam int W = 16;
  localparam int NS = W / 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  cla_seq_addsub_if #(.WIDTH(W)) bus ();

  cla_seq_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic [15:0] res;
    logic        ov;
    logic        co;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic s, input logic sat,
                                output logic [15:0] r, output logic ov, output logic co);
    int sa;
    int sb;
    int t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = s ? sa - sb : sa + sb;
    ov = (t > 32767) || (t < -32768);
    co = s ? (a >= b) : ((32'(a) + 32'(b)) > 32'h0000_FFFF);
    r  = s ? a - b : a + b;
    if (sat && ov) r = (t > 0) ? 16'h7FFF : 16'h8000;
  endfunction

  task automatic drive_start(input logic [15:0] a, input logic [15:0] b,
                             input logic s, input logic sat);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.sub    = s;
    bus.sat_en = sat;
  endtask

  // From a negedge just after the accepting edge: count RUN cycles until done shows
  task automatic wait_done(output int n_busy, output logic seen);
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) n_busy++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic sat,
                        input logic [15:0] er, input logic eo, input logic ec);
    int   nb;
    logic seen;
    @(negedge clk);
    drive_start(a, b, s, sat);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(nb, seen);
    check({name, ".done"}, 32'(seen), 32'd1);
    check({name, ".busy_cycles"}, 32'(nb), 32'(NS));
    check({name, ".busy_with_done"}, 32'(bus.busy), 32'd0);
    check({name, ".result"}, 32'(bus.result), 32'(er));
    check({name, ".ovfl"}, 32'(bus.ovfl), 32'(eo));
    check({name, ".cout"}, 32'(bus.cout), 32'(ec));
  endtask

  initial begin
    int          nb;
    logic        seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic        rsat;
    logic [15:0] er;
    logic        eo;
    logic        ec;
    int          gap;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.sat_en = 1'b0;

    vecs.push_back('{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.result", 32'(bus.result), 32'd0);
    check("reset.ovfl", 32'(bus.ovfl), 32'd0);
    check("reset.cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat,
             vecs[i].res, vecs[i].ov, vecs[i].co);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rsat = 1'($urandom);
      if (i % 5 == 0) rb = 16'h8000;
      model(ra, rb, rs, rsat, er, eo, ec);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, rsat, er, eo, ec);
    end

    // start pulses during RUN are ignored; start in DONE chains the next op without gap
    @(negedge clk);
    drive_start(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    drive_start(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    wait_done(nb, seen);
    check("ignore.done", 32'(seen), 32'd1);
    check("ignore.result", 32'(bus.result), 32'h3333);
    drive_start(16'h0100, 16'h0200, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b.busy_next", 32'(bus.busy), 32'd1);
    gap = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      gap++;
      @(negedge clk);
    end
    check("b2b.done", 32'(seen), 32'd1);
    check("b2b.gap", 32'(gap), 32'(NS + 1));
    check("b2b.result", 32'(bus.result), 32'hFF00);
    check("b2b.cout", 32'(bus.cout), 32'd0);

    // reset on the second RUN cycle discards the op
    @(negedge clk);
    drive_start(16'h4000, 16'h4000, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_mid.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.busy", 32'(bus.busy), 32'd0);
    check("rst_mid.done", 32'(bus.done), 32'd0);
    check("rst_mid.result", 32'(bus.result), 32'd0);
    check("rst_mid.ovfl", 32'(bus.ovfl), 32'd0);
    check("rst_mid.cout", 32'(bus.cout), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_mid.no_done", 32'(seen), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cla_seq_addsub.md
Name: cla_seq_addsub

Overview:
Multi-cycle controller that runs a WIDTH-bit add or subtract through one shared 4-bit carry-lookahead slice (CLA_4bit), one slice per cycle, LSB slice first.
It registers the inter-slice carry and assembles the result.
It computes signed overflow and optionally saturates the result, as required by the ALU's saturating ADD/SUB.
It sits between the ALU decode and the 4-bit CLA slice, in area-reduced datapath configurations.

Parameters:
WIDTH, 16, operand/result width; must be a positive multiple of 4.
NSLICE, WIDTH/4, derived slice count; not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  1 = a - b, 0 = a + b; latched with start
sat_en  input  1  1 = saturate on signed overflow; latched with start
a  input  WIDTH  operand A; latched with start
b  input  WIDTH  operand B; latched with start
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
result  output  WIDTH  final sum/difference; valid from done, held until next accepted start
ovfl  output  1  signed overflow of the unsaturated result; same validity as result
cout  output  1  carry out of MSB slice (for sub: 1 = no borrow); same validity as result

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-RUN):
  - state=IDLE, slice index=0, carry reg=0.
  - busy=0, done=0, result=0, ovfl=0, cout=0.
  - An in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge:
  - Latch a into opA.
  - Latch b into opB, stored as ~b if sub=1.
  - Latch sub and sat_en.
  - carry reg := sub; idx := 0; go to RUN.
  - result/ovfl/cout keep their old values until the final commit.
- DONE with start=0 -> IDLE. IDLE with start=0 stays in IDLE. DONE lasts exactly one cycle unless a start is accepted there, which gives back-to-back throughput of one op per NSLICE+1 cycles.
- RUN, each edge:
  - The CLA slice computes opA[4*idx+:4] + opB[4*idx+:4] + carry reg.
  - The sum nibble is written into an internal sum register at [4*idx+:4].
  - carry reg := slice Cout; idx := idx+1.
  - start is ignored in RUN.
- Final slice edge (idx = NSLICE-1):
  - ovfl := (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]), using the post-inversion opB.
  - cout := slice Cout.
  - Result:
    - If sat_en and ovfl: result := 0x7FFF..F when opA[MSB]=0, else 0x800..0.
    - Otherwise result := the assembled sum.
  - Go to DONE.
- Latency: if start is accepted at edge E0, done=1 in the cycle after edge E0+NSLICE (4 edges for WIDTH=16).
- busy=1 exactly for the NSLICE cycles in RUN. done and busy are never high together.
- Slice Prop_Val/Gen_Val outputs are unused. Only the slice Sum and Cout are consumed.
- Wrap-around: unsigned wrap is natural; 0xFFFF+0x0001 = 0x0000 with cout=1, ovfl=0.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  - localparam SLICE_W = 4.
- Sub-module: one instance of the existing CLA_4bit slice; no other sub-modules.
- Saturation constants are derived in-module from WIDTH.

Test Plan:
- a=0x1234, b=0x0FCD, sub=0, sat_en=0 -> busy high 4 cycles, then done pulse; result=0x2201, cout=0, ovfl=0.
- a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, ovfl=0. Repeat with a=0x0007, b=0x0005 -> result=0x0002, cout=1.
- a=0x7FFF, b=0x0001, sub=0: sat_en=0 -> result=0x8000, ovfl=1; sat_en=1 -> result=0x7FFF, ovfl=1.
- a=0x8000, b=0x0001, sub=1, sat_en=1 -> result=0x8000, ovfl=1. Also a=0xFFFF, b=0x0001, add -> result=0x0000, cout=1, ovfl=0.
- Start an op, pulse start with different operands during RUN -> ignored, first op's result correct. Assert start in the DONE cycle -> second op accepted with no IDLE gap, second done 5 cycles after the first.
- Assert rst on the 2nd RUN cycle -> next cycle IDLE with all outputs 0 and no done pulse. A following op (0x0001+0x0001) -> result=0x0002.
